// File: rtl/rf_pkg.sv
// Shared constants, types and helpers for the multiport register file.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  function automatic int rf_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  typedef logic [XLEN_DEF-1:0]                    word_t;
  typedef logic [rf_clog2(NREGS_DEF)-1:0] addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: flush > alloc > write-clear priority per register, x0 never pending.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = rf_clog2(NREGS_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [AW-1:0]     alloc_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NREGS-1:0]  pending,
  output logic [NRD-1:0]    rd_ready
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    pending_d[0] = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (flush) begin
        pending_d[i] = 1'b0;
      end else if (alloc_valid && (alloc_addr == AW'(i))) begin
        pending_d[i] = 1'b1;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(i))) pending_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  always_comb begin
    rd_ready = '1;
    for (int k = 0; k < NRD; k++) begin
      rd_ready[k] = ~pending_q[rd_addr[k*AW +: AW]];
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/rf_multiport_sb.sv
// Multiport register file with pending-write scoreboard; x0 reads zero.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module rf_multiport_sb
  import rf_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = rf_clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_ready,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    pending
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NRD-1:0]  rdy_raw;

  // Ascending port order lets the highest-indexed port win a collision.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .pending     (pending),
    .rd_ready    (rdy_raw)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rdy;

    assign ra = rd_addr[k*AW +: AW];

    always_comb begin
      rdat = (ra == AW'(ZERO_REG)) ? '0 : regs_q[ra];
      rdy  = rdy_raw[k];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == ra) && (ra != AW'(ZERO_REG))) begin
          rdat = wr_data[j*XLEN +: XLEN];
          // A same-cycle alloc re-arms pending, so readiness is not forced.
          if (!(alloc_valid && !flush && (alloc_addr == ra))) rdy = 1'b1;
        end
      end
`endif
    end

    assign rd_data[k*XLEN +: XLEN] = rdat;
    assign rd_ready[k] = rdy;
  end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed self-checking bench for rf_multiport_sb (expectations follow REGFILE_BYPASS_EN).
module tb_rf_multiport_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic        flush;
  logic [31:0] pending;

  int checks   = 0;
  int failures = 0;

  rf_multiport_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .flush       (flush),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 2'b00;
    alloc_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0;
    #3;
    chk("rst_pending", pending, 0);
    chk("rst_ready", rd_ready, 2'b11);
    #9 rst = 1'b1;
    #1;

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("rst_data_x%0d", a), rd_data, 64'h0);
      chk($sformatf("rst_rdy_x%0d", a), rd_ready, 2'b11);
    end
    chk("rst_pending_after", pending, 0);

    tick();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    tick();
    idle(); rd_addr = {5'd0, 5'd5};
    #1;
    chk("wr_x5", rd_data[31:0], 32'hDEADBEEF);

    wr_en = 2'b10; wr_addr = {5'd0, 5'd0}; wr_data = {32'h1234, 32'h0};
    tick();
    idle(); rd_addr = {5'd5, 5'd0};
    #1;
    chk("wr_x0_dropped", rd_data, {32'hDEADBEEF, 32'h0});

    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h5555FFFF, 32'hAAAA0000};
    tick();
    idle(); rd_addr = {5'd7, 5'd7};
    #1;
    chk("collision_x7", rd_data, {32'h5555FFFF, 32'h5555FFFF});
    chk("collision_pending", pending, 0);

    alloc_valid = 1'b1; alloc_addr = 5'd9;
    tick();
    idle(); rd_addr = {5'd9, 5'd9};
    #1;
    chk("alloc_x9_pending", pending, 32'h0000_0200);
    chk("alloc_x9_ready", rd_ready, 2'b00);

    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h99, 32'h0};
    tick();
    idle();
    #1;
    chk("wr_x9_clear", pending, 0);
    chk("wr_x9_ready", rd_ready, 2'b11);
    chk("wr_x9_data", rd_data, {32'h99, 32'h99});

    alloc_valid = 1'b1; alloc_addr = 5'd9;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h77};
    tick();
    idle();
    #1;
    chk("alloc_beats_wr", pending, 32'h0000_0200);
    chk("alloc_beats_wr_data", rd_data[31:0], 32'h77);

    alloc_valid = 1'b1; alloc_addr = 5'd3;
    tick();
    idle();
    #1;
    chk("alloc_x3", pending, 32'h0000_0208);

    flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 5'd3;
    tick();
    idle();
    #1;
    chk("flush_over_alloc", pending, 0);

    alloc_valid = 1'b1; alloc_addr = 5'd12;
    tick();
    idle(); rd_addr = {5'd0, 5'd12};
    #1;
    chk("alloc_x12_ready", rd_ready, 2'b10);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h0000_00FF};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_data", rd_data[31:0], 32'h0000_00FF);
    chk("bypass_ready", rd_ready, 2'b11);
`else
    chk("nobypass_data", rd_data[31:0], 32'h0);
    chk("nobypass_ready", rd_ready, 2'b10);
`endif
    tick();
    idle();
    #1;
    chk("x12_next", rd_data[31:0], 32'h0000_00FF);
    chk("x12_ready_next", rd_ready, 2'b11);

    alloc_valid = 1'b1; alloc_addr = 5'd20;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd21}; wr_data = {32'h0, 32'hABCD};
    tick();
    idle(); rd_addr = {5'd20, 5'd21};
    #1;
    chk("pre_rst_pending", pending, 32'h0010_0000);
    chk("pre_rst_data", rd_data[31:0], 32'hABCD);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_data", rd_data, 64'h0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_ready", rd_ready, 2'b11);
    #4 rst = 1'b1;
    tick();
    wr_en = 2'b10; wr_addr = {5'd21, 5'd0}; wr_data = {32'h1111, 32'h0};
    tick();
    idle(); rd_addr = {5'd5, 5'd21};
    #1;
    chk("post_rst_wr", rd_data, {32'h0, 32'h1111});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
